// File: rtl/mmu_sequencer.sv
// Sequencer for one matrix-multiply pass on a weight-stationary systolic array:
// weight preload, skewed activation streaming and per-column result-valid flags.
module mmu_sequencer #(
    parameter int ARR_SIZE      = 2,
    parameter int VERTICAL_BW   = 32,
    parameter int HORIZONTAL_BW = 16,
    parameter int ROW_W         = 8,
    parameter int WADDR_W       = $clog2(ARR_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROW_W-1:0]                  num_rows,
    output logic                              busy,
    output logic                              done,
    output logic                              w_rd_en,
    output logic [WADDR_W-1:0]                w_rd_addr,
    input  logic [VERTICAL_BW*ARR_SIZE-1:0]   w_rd_data,
    output logic                              a_rd_en,
    output logic [ROW_W-1:0]                  a_rd_addr,
    input  logic [HORIZONTAL_BW*ARR_SIZE-1:0] a_rd_data,
    output logic                              mmu_mode,
    output logic [VERTICAL_BW*ARR_SIZE-1:0]   mmu_vertical,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] mmu_horizontal,
    output logic [ARR_SIZE-1:0]               out_valid
);

    // One counter serves every state; it must reach M-1 and the 2N drain count.
    localparam int DRAIN_W = $clog2(2 * ARR_SIZE + 1);
    localparam int CNT_W   = (ROW_W > DRAIN_W) ? ROW_W : DRAIN_W;

    localparam logic [CNT_W-1:0]   LOAD_LAST  = CNT_W'(ARR_SIZE - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST = CNT_W'(2 * ARR_SIZE);
    localparam logic [WADDR_W-1:0] W_TOP      = WADDR_W'(ARR_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_COMPUTE,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   rows_q, rows_d;

    logic                              w_vld_q;
    logic                              mode_q;
    logic [VERTICAL_BW*ARR_SIZE-1:0]   vert_q;
    logic                              a_vld_q;
    logic [HORIZONTAL_BW*ARR_SIZE-1:0] row_q;
    logic [2*ARR_SIZE-1:0]             vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rows_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rows_q  <= rows_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rows_d    = rows_q;
        w_rd_en   = 1'b0;
        w_rd_addr = '0;
        a_rd_en   = 1'b0;
        a_rd_addr = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start && (num_rows != '0)) begin
                    rows_d  = num_rows;
                    cnt_d   = '0;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                w_rd_en   = 1'b1;
                w_rd_addr = W_TOP - cnt_q[WADDR_W-1:0];
                if (cnt_q == LOAD_LAST) begin
                    cnt_d   = '0;
                    state_d = S_COMPUTE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COMPUTE: begin
                a_rd_en   = 1'b1;
                a_rd_addr = cnt_q[ROW_W-1:0];
                if (cnt_q[ROW_W-1:0] == rows_q - ROW_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    // Weight rows return one cycle after the read and are registered once more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_vld_q <= 1'b0;
            mode_q  <= 1'b0;
            vert_q  <= '0;
            a_vld_q <= 1'b0;
            row_q   <= '0;
            vld_q   <= '0;
        end else begin
            w_vld_q <= w_rd_en;
            mode_q  <= w_vld_q;
            vert_q  <= w_vld_q ? w_rd_data : '0;
            a_vld_q <= a_rd_en;
            row_q   <= a_vld_q ? a_rd_data : '0;
            vld_q   <= {vld_q[2*ARR_SIZE-2:0], a_vld_q};
        end
    end

    assign mmu_mode     = mode_q;
    assign mmu_vertical = vert_q;

    // vld_q[i] is the lane-0 token i cycles late; column j reports after N+j hops.
    assign out_valid = vld_q[2*ARR_SIZE-1:ARR_SIZE];

    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
        if (k == 0) begin : g_direct
            assign mmu_horizontal[0 +: HORIZONTAL_BW] = row_q[0 +: HORIZONTAL_BW];
        end else begin : g_skew
            logic [HORIZONTAL_BW-1:0] sr_q [k];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int unsigned i = 0; i < k; i++) begin
                        sr_q[i] <= '0;
                    end
                end else begin
                    sr_q[0] <= row_q[k*HORIZONTAL_BW +: HORIZONTAL_BW];
                    for (int unsigned i = 1; i < k; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign mmu_horizontal[k*HORIZONTAL_BW +: HORIZONTAL_BW] = sr_q[k-1];
        end
    end

endmodule
